// File: rtl/rv_immgen_stage.sv
// rv_immgen_stage: registered immediate generator for the decode path.
// Decodes one 32-bit instruction per handshake into an extended immediate,
// a format code and an illegal flag. A main register drives the outputs and
// a skid register absorbs one extra beat so that o_in_ready is a flop.
module rv_immgen_stage #(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [31:0]   i_in_instr,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_out_imm,
  output logic [2:0]    o_out_fmt,
  output logic          o_out_illegal
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CSRI  = 3'd7;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_IMM32   = 7'b0011011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_OP32    = 7'b0111011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  localparam bit RV64 = (DW == 64);

  logic [6:0]    w_opcode;
  logic [2:0]    w_f3;
  logic [31:0]   w_val;
  logic          w_sext;
  logic [2:0]    w_fmt;
  logic          w_ill;
  logic [DW-1:0] w_imm;
  logic          w_push;
  logic          w_main_free;

  logic          r_main_valid;
  logic [DW-1:0] r_main_imm;
  logic [2:0]    r_main_fmt;
  logic          r_main_ill;
  logic          r_skid_valid;
  logic [DW-1:0] r_skid_imm;
  logic [2:0]    r_skid_fmt;
  logic          r_skid_ill;
  logic          r_in_ready;

  assign w_opcode = i_in_instr[6:0];
  assign w_f3     = i_in_instr[14:12];

  // Decode the offered instruction into a 32-bit value plus a widening mode.
  always_comb begin
    w_val  = '0;
    w_sext = 1'b0;
    w_fmt  = FMT_NONE;
    w_ill  = 1'b0;
    if (i_in_instr[1:0] != 2'b11) begin
      w_ill = 1'b1;
    end else begin
      case (w_opcode)
        OP_JALR, OP_LOAD: begin
          w_fmt  = FMT_I;
          w_val  = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
          w_sext = 1'b1;
        end
        OP_IMM, OP_IMM32: begin
          if (w_opcode == OP_IMM32 && !RV64) begin
            w_ill = 1'b1;
          end else if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
            w_fmt = FMT_SHAMT;
            if (w_opcode == OP_IMM && RV64) begin
              w_val = {26'd0, i_in_instr[25:20]};
            end else begin
              // Word shifts and RV32 shifts only have five shamt bits.
              w_val = {27'd0, i_in_instr[24:20]};
              w_ill = (w_opcode == OP_IMM) && i_in_instr[25];
            end
          end else begin
            w_fmt  = FMT_I;
            w_val  = {{20{i_in_instr[31]}}, i_in_instr[31:20]};
            w_sext = 1'b1;
          end
        end
        OP_STORE: begin
          w_fmt  = FMT_S;
          w_val  = {{20{i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
          w_sext = 1'b1;
        end
        OP_BRANCH: begin
          w_fmt  = FMT_B;
          w_val  = {{19{i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                    i_in_instr[30:25], i_in_instr[11:8], 1'b0};
          w_sext = 1'b1;
        end
        OP_LUI, OP_AUIPC: begin
          w_fmt  = FMT_U;
          w_val  = {i_in_instr[31:12], 12'd0};
          w_sext = 1'b1;
        end
        OP_JAL: begin
          w_fmt  = FMT_J;
          w_val  = {{11{i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                    i_in_instr[20], i_in_instr[30:21], 1'b0};
          w_sext = 1'b1;
        end
        OP_SYSTEM: begin
          if (w_f3[2] && w_f3[1:0] != 2'b00) begin
            w_fmt = FMT_CSRI;
            w_val = {27'd0, i_in_instr[19:15]};
          end
        end
        OP_OP, OP_MISCMEM: begin
          w_fmt = FMT_NONE;
        end
        OP_OP32: begin
          w_ill = !RV64;
        end
        default: begin
          w_ill = 1'b1;
        end
      endcase
    end
  end

  assign w_imm       = w_sext ? DW'($signed(w_val)) : DW'(w_val);
  assign w_push      = i_in_valid && r_in_ready;
  assign w_main_free = !r_main_valid || i_out_ready;

  // Main/skid buffer: skid refills main first, so entries leave in order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_fmt   <= FMT_NONE;
      r_main_ill   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_fmt   <= FMT_NONE;
      r_skid_ill   <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // o_in_ready was low, so no new beat can collide with this move.
        r_main_valid <= 1'b1;
        r_main_imm   <= r_skid_imm;
        r_main_fmt   <= r_skid_fmt;
        r_main_ill   <= r_skid_ill;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else if (w_push) begin
        r_main_valid <= 1'b1;
        r_main_imm   <= w_imm;
        r_main_fmt   <= w_fmt;
        r_main_ill   <= w_ill;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_push) begin
      r_skid_valid <= 1'b1;
      r_skid_imm   <= w_imm;
      r_skid_fmt   <= w_fmt;
      r_skid_ill   <= w_ill;
      r_in_ready   <= 1'b0;
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_out_valid   = r_main_valid;
  assign o_out_imm     = r_main_imm;
  assign o_out_fmt     = r_main_fmt;
  assign o_out_illegal = r_main_ill;

endmodule

// File: doc/rv_immgen_stage.md
# rv_immgen_stage

Registered, flow-controlled immediate-generation stage for the decode path. Accepts one 32-bit instruction per cycle over a valid/ready handshake and produces the extended DW-bit immediate, a format code and an illegal-opcode flag one cycle later. It also covers the cases the combinational generator omits: AUIPC, shift amounts, CSR zimm, RV64 word opcodes and compressed-encoding rejection. A two-entry skid buffer keeps `in_ready` registered, so the stage sits between fetch and the register-read stage without a combinational ready path.

## Interface
- `DW`, 32, immediate/output width; legal values 32 or 64; 64 enables RV64 decoding.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage can accept; driven from a register.
- `in_instr`  in  32  instruction word.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_imm`  out  DW  immediate.
- `out_fmt`  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSRI.
- `out_illegal`  out  1  opcode is not recognised for this DW.

## Operation
- Decoding uses `in_instr[6:0]`. If `in_instr[1:0]` is not 2'b11, the result is illegal with fmt NONE and imm 0.
- I format:
  - Applies to JALR 1100111, LOAD 0000011, and OP-IMM 0010011 except shifts.
  - imm is the sign extension of `[31:20]`.
- S format: STORE 0100011; sign extension of `{[31:25],[11:7]}`.
- B format: BRANCH 1100011; sign extension of `{[31],[7],[30:25],[11:8],0}`.
- U format: LUI 0110111 and AUIPC 0010111; `{[31:12],12'b0}`, sign-extended to DW.
- J format: JAL 1101111; sign extension of `{[31],[19:12],[20],[30:21],0}`.
- SHAMT format:
  - Applies to OP-IMM with funct3 001 or 101.
  - imm is the zero-extended `[24:20]` when DW=32, or `[25:20]` when DW=64.
  - When DW=32, `[25]`=1 sets illegal.
- CSRI format: SYSTEM 1110011 with funct3 101, 110 or 111; imm is the zero-extended `[19:15]`.
- NONE format with imm 0 and legal: OP 0110011, MISC-MEM 0001111, and SYSTEM with any other funct3.
- RV64 word opcodes:
  - OP-IMM-32 0011011 follows the OP-IMM rules, with the shamt always `[24:20]`.
  - OP-32 0111011 is NONE.
  - Both opcodes are illegal when DW=32.
- Any other opcode is illegal: fmt NONE, imm 0.
- Buffering:
  - Main register: feeds the outputs directly.
  - Skid register: holds one extra entry.
  - `in_ready` = !skid_valid, registered.
  - Entries leave in arrival order; no reordering and no duplication.

## Timing
- Reset values:
  - `out_valid` 0, `out_imm` 0, `out_fmt` 0, `out_illegal` 0.
  - `in_ready` 1; the skid register is empty.
- Input handshake: a beat transfers when `in_valid && in_ready` at a rising edge.
- Latency: an instruction accepted at edge N is presented at the outputs from edge N (visible in cycle N+1).
- Throughput: with `out_ready` held at 1, the stage sustains 1 instruction per cycle indefinitely.
- Output stability: while `out_valid && !out_ready`, `out_imm`, `out_fmt` and `out_illegal` are stable.
- Stall while main is full and `out_ready`=0:
  - The next accepted beat goes into skid.
  - `in_ready` falls at the following edge.
- Drain:
  - On the first edge with `out_ready`=1, main takes the skid entry.
  - `in_ready` returns to 1 at that same edge.
- Simultaneous pop and push:
  - If skid is empty, main loads the new beat directly.
  - If skid is full, skid moves to main. No new beat can arrive, because `in_ready`=0.
- Flush:
  - At the edge, `out_valid` goes to 0 and skid is cleared.
  - A beat presented in the flush cycle is dropped.
  - `in_ready` is 1 in the next cycle.
  - Flush has priority over push and pop.
- Asynchronous reset mid-stream:
  - Takes effect immediately and discards all entries.
  - The first acceptance is at the first rising edge after `rst_n` rises.

## Test plan
- Formats, DW=32, streamed with `out_ready`=1, one result per cycle in order:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt I.
  - 0xFE112E23 -> 0xFFFFFFFC, fmt S.
  - 0xFF9FF06F -> 0xFFFFFFF8, fmt J.
  - 0x123452B7 -> 0x12345000, fmt U.
- SHAMT/CSRI, DW=32:
  - 0x4030D093 -> imm 3, fmt SHAMT.
  - 0x300FD073 -> imm 31, fmt CSRI.
  - 0x0200D093 (shamt bit 25 set) -> illegal 1.
- Illegal and compressed, DW=32:
  - 0x00000000 -> illegal 1, imm 0, fmt NONE.
  - 0x0000001B (OP-IMM-32) -> illegal 1.
- DW=64:
  - 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt U.
  - 0x03F09093 -> imm 63, fmt SHAMT, illegal 0.
- Backpressure: stream 8 instructions with `out_ready` held at 0 for 4 cycles after the first result.
  - `in_ready` drops after the 2nd beat is accepted.
  - All 8 results emerge in order with no loss.
  - Outputs are stable during the stall.
- Flush/reset: with both entries full, pulse `flush`.
  - Next cycle: `out_valid`=0 and `in_ready`=1.
  - Repeat with `rst_n` asserted mid-cycle: outputs go to reset values immediately.
